shmem_req_scheduler: RTL and testbench

SHMEM_REQ_SCHEDULER -- requirements
Module: shmem_req_scheduler

---
 rtl/shmem_pkg.sv | 13 +
 rtl/shmem_req_slot.sv | 101 ++++++++++
 rtl/shmem_req_scheduler.sv | 73 +++++++
 tb/tb_shmem_req_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shmem_pkg.sv
// shmem_pkg: shared core count, request field widths and per-slot state encoding
package shmem_pkg;
   localparam int NCORES_DEF = 16;
   localparam int BANK_W     = 4;
   localparam int OFFSET_W   = 8;
   localparam int ADDR_W     = BANK_W + OFFSET_W;
   localparam int DATA_W     = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } slot_state_t;
endpackage

// File: rtl/shmem_req_slot.sv
// shmem_req_slot: one core's request FSM with latched request, timeout timer and response capture
module shmem_req_slot
   import shmem_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr_in,
   output logic [DATA_W-1:0] data_in,
   input  logic              finish,
   input  logic [DATA_W-1:0] data_out,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              busy_next
);
   localparam int TW = $clog2(TIMEOUT);

   slot_state_t   state, state_next;
   logic          we_q, err_q, err_next, expired;
   logic [TW-1:0] timer;

   assign expired   = timer == TW'(TIMEOUT - 1);
   assign busy      = state == BUSY;
   assign busy_next = state_next == BUSY;

   // state register; reset drops any in-flight request without a response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         err_q <= 1'b0;
      end else begin
         state <= state_next;
         err_q <= err_next;
      end
   end

   // next state and per-state strobes; finish takes priority over the timeout
   always_comb begin
      state_next = state;
      err_next   = err_q;
      req_ready  = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = BUSY;
         end
         BUSY: begin
            read  = !we_q;
            write = we_q;
            if (finish) begin
               state_next = DONE;
               err_next   = 1'b0;
            end else if (expired) begin
               state_next = DONE;
               err_next   = 1'b1;
            end
         end
         DONE: begin
            rsp_valid  = 1'b1;
            rsp_err    = err_q;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // request latches, BUSY-cycle timer and read-data capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         we_q     <= 1'b0;
         addr_in  <= '0;
         data_in  <= '0;
         timer    <= '0;
         rsp_data <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_in <= req_addr;
            data_in <= req_wdata;
            timer   <= '0;
         end else if (state == BUSY && !finish) begin
            timer <= timer + TW'(1);
         end
         if (state == BUSY && finish && !we_q) rsp_data <= data_out;
      end
   end
endmodule

// File: rtl/shmem_req_scheduler.sv
// shmem_req_scheduler: per-core request slots feeding the bank arbiters, plus busy and spurious-finish accounting
module shmem_req_scheduler
   import shmem_pkg::*;
#(
   parameter int NCORES  = NCORES_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NCORES-1:0]        req_valid,
   input  logic [NCORES-1:0]        req_we,
   input  logic [ADDR_W*NCORES-1:0] req_addr,
   input  logic [DATA_W*NCORES-1:0] req_wdata,
   output logic [NCORES-1:0]        req_ready,
   output logic [NCORES-1:0]        read,
   output logic [NCORES-1:0]        write,
   output logic [ADDR_W*NCORES-1:0] addr_in,
   output logic [DATA_W*NCORES-1:0] data_in,
   input  logic [NCORES-1:0]        finish,
   input  logic [DATA_W*NCORES-1:0] data_out,
   output logic [NCORES-1:0]        rsp_valid,
   output logic [NCORES-1:0]        rsp_err,
   output logic [DATA_W*NCORES-1:0] rsp_data,
   output logic [4:0]               busy_cnt,
   output logic [7:0]               spurious_cnt
);
   logic [NCORES-1:0] busy, busy_next;
   logic [4:0]        busy_sum;
   logic              spurious;

   for (genvar i = 0; i < NCORES; i++) begin : g_slot
      shmem_req_slot #(.TIMEOUT(TIMEOUT)) u_slot (
         .clock     (clock),
         .reset     (reset),
         .req_valid (req_valid[i]),
         .req_we    (req_we[i]),
         .req_addr  (req_addr[ADDR_W*i +: ADDR_W]),
         .req_wdata (req_wdata[DATA_W*i +: DATA_W]),
         .req_ready (req_ready[i]),
         .read      (read[i]),
         .write     (write[i]),
         .addr_in   (addr_in[ADDR_W*i +: ADDR_W]),
         .data_in   (data_in[DATA_W*i +: DATA_W]),
         .finish    (finish[i]),
         .data_out  (data_out[DATA_W*i +: DATA_W]),
         .rsp_valid (rsp_valid[i]),
         .rsp_err   (rsp_err[i]),
         .rsp_data  (rsp_data[DATA_W*i +: DATA_W]),
         .busy      (busy[i]),
         .busy_next (busy_next[i])
      );
   end

   // any finish bit landing on a slot that is not BUSY counts once per cycle
   assign spurious = |(finish & ~busy);

   // population count of slots that will be BUSY after the coming edge
   always_comb begin
      busy_sum = '0;
      for (int k = 0; k < NCORES; k++) busy_sum = busy_sum + 5'(busy_next[k]);
   end

   // registered busy population and saturating spurious-finish counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_cnt     <= '0;
         spurious_cnt <= '0;
      end else begin
         busy_cnt <= busy_sum;
         if (spurious && spurious_cnt != 8'hFF) spurious_cnt <= spurious_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_shmem_req_scheduler.sv
// tb_shmem_req_scheduler: directed and random checks against a cycle-count reference model
module tb_shmem_req_scheduler;
   localparam int N   = 16;
   localparam int TMO = 64;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0, req_we = '0, finish = '0;
   logic [12*N-1:0] req_addr = '0;
   logic [8*N-1:0]  req_wdata = '0, data_out = '0;
   logic [N-1:0]    req_ready, read, write, rsp_valid, rsp_err;
   logic [12*N-1:0] addr_in;
   logic [8*N-1:0]  data_in, rsp_data;
   logic [4:0]      busy_cnt;
   logic [7:0]      spurious_cnt;
   logic [N-1:0]    t_req_ready, t_read, t_write, t_rsp_valid, t_rsp_err;
   logic [12*N-1:0] t_addr_in;
   logic [8*N-1:0]  t_data_in, t_rsp_data;
   logic [4:0]      t_busy_cnt;
   logic [7:0]      t_spurious_cnt;

   int vectors = 0, miscompares = 0;

   // reference model: a request is outstanding from its accept edge t0 and
   // its response pulse is due for the single cycle after it resolves
   bit         pend[N], resp[N], rerr[N], we_m[N];
   int         t0[N];
   logic [11:0] a_m[N];
   logic [7:0]  wd_m[N], rd_m[N];
   int         spur, cyc;

   shmem_req_scheduler #(.NCORES(N), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .read(read), .write(write), .addr_in(addr_in), .data_in(data_in),
      .finish(finish), .data_out(data_out), .rsp_valid(rsp_valid),
      .rsp_err(rsp_err), .rsp_data(rsp_data), .busy_cnt(busy_cnt),
      .spurious_cnt(spurious_cnt)
   );

   shmem_req_scheduler #(.NCORES(N), .TIMEOUT(8)) dut8 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(t_req_ready),
      .read(t_read), .write(t_write), .addr_in(t_addr_in), .data_in(t_data_in),
      .finish(finish), .data_out(data_out), .rsp_valid(t_rsp_valid),
      .rsp_err(t_rsp_err), .rsp_data(t_rsp_data), .busy_cnt(t_busy_cnt),
      .spurious_cnt(t_spurious_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; resp[i] = 0; rerr[i] = 0; we_m[i] = 0; t0[i] = 0;
         a_m[i] = '0; wd_m[i] = '0; rd_m[i] = '0;
      end
      spur = 0;
      cyc  = 0;
   endtask

   task automatic model_edge();
      bit sp = 0;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (resp[i]) begin
            resp[i] = 0;
            if (finish[i]) sp = 1;
         end else if (pend[i]) begin
            if (finish[i]) begin
               pend[i] = 0; resp[i] = 1; rerr[i] = 0;
               if (!we_m[i]) rd_m[i] = data_out[8*i +: 8];
            end else if (cyc - 1 - t0[i] == TMO - 1) begin
               pend[i] = 0; resp[i] = 1; rerr[i] = 1;
            end
         end else begin
            if (finish[i]) sp = 1;
            if (req_valid[i]) begin
               pend[i] = 1; t0[i] = cyc; we_m[i] = req_we[i];
               a_m[i] = req_addr[12*i +: 12]; wd_m[i] = req_wdata[8*i +: 8];
            end
         end
      end
      if (sp && spur < 255) spur++;
   endtask

   task automatic compare_all();
      logic [N-1:0]    e_rdy, e_rd, e_wr, e_rv, e_re;
      logic [12*N-1:0] e_a;
      logic [8*N-1:0]  e_d, e_rdat;
      int nb = 0;
      for (int i = 0; i < N; i++) begin
         e_rdy[i] = !pend[i] && !resp[i];
         e_rd[i]  = pend[i] && !we_m[i];
         e_wr[i]  = pend[i] && we_m[i];
         e_rv[i]  = resp[i];
         e_re[i]  = resp[i] && rerr[i];
         e_a[12*i +: 12]  = a_m[i];
         e_d[8*i +: 8]    = wd_m[i];
         e_rdat[8*i +: 8] = rd_m[i];
         nb += int'(pend[i]);
      end
      chk("req_ready", req_ready, e_rdy);
      chk("read", read, e_rd);
      chk("write", write, e_wr);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err", rsp_err, e_re);
      chk("addr_in", addr_in, e_a);
      chk("data_in", data_in, e_d);
      chk("rsp_data", rsp_data, e_rdat);
      chk("busy_cnt", busy_cnt, 192'(nb));
      chk("spurious_cnt", spurious_cnt, 192'(spur));
   endtask

   task automatic step();
      if (reset) model_edge();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic set_req(input int i, input logic we, input logic [11:0] a, input logic [7:0] d);
      req_valid[i] = 1'b1;
      req_we[i] = we;
      req_addr[12*i +: 12] = a;
      req_wdata[8*i +: 8] = d;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      finish = '0;
      req_valid = '0;
      #1;
      model_clear();
      compare_all();
      step();
      step();
      #3 reset = 1'b1;
   endtask

   initial begin
      int hi;
      #1;
      apply_reset();
      chk("reset_ready", req_ready, 192'hFFFF);

      // core 3 read of 0x5A7, finish in the fourth BUSY cycle
      set_req(3, 1'b0, 12'h5A7, 8'h00);
      step();
      req_valid = '0;
      chk("r39_addr", addr_in[36 +: 12], 192'h5A7);
      hi = int'(read[3]);
      for (int k = 0; k < 3; k++) begin
         step();
         hi += int'(read[3]);
      end
      finish[3] = 1'b1;
      data_out[24 +: 8] = 8'h3C;
      step();
      finish = '0;
      chk("r39_read_cycles", 192'(hi), 192'd4);
      chk("r39_rsp_valid", rsp_valid[3], 192'd1);
      chk("r39_rsp_err", rsp_err[3], 192'd0);
      chk("r39_rsp_data", rsp_data[31:24], 192'h3C);
      chk("r39_read_low", read[3], 192'd0);
      step();
      chk("r39_pulse_end", rsp_valid[3], 192'd0);

      // core 0 write with finish in the first BUSY cycle
      set_req(0, 1'b1, 12'h012, 8'h11);
      step();
      req_valid = '0;
      chk("r40_write", write[0], 192'd1);
      chk("r40_data_in", data_in[7:0], 192'h11);
      finish[0] = 1'b1;
      data_out[7:0] = 8'hEE;
      step();
      finish = '0;
      chk("r40_write_low", write[0], 192'd0);
      chk("r40_rsp_valid", rsp_valid[0], 192'd1);
      chk("r40_rsp_data", rsp_data[7:0], 192'h00);
      step();

      // TIMEOUT=8 instance: core 7 read never finishes
      apply_reset();
      set_req(7, 1'b0, 12'h7FF, 8'h00);
      step();
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         chk("r41_read_busy", t_read[7], 192'd1);
         chk("r41_no_rsp", t_rsp_valid[7], 192'd0);
         step();
      end
      chk("r41_rsp_valid", t_rsp_valid[7], 192'd1);
      chk("r41_rsp_err", t_rsp_err[7], 192'd1);
      chk("r41_read_low", t_read[7], 192'd0);
      step();
      chk("r41_after_read", t_read[7], 192'd0);
      chk("r41_after_rsp", t_rsp_valid[7], 192'd0);
      chk("r41_ready", t_req_ready[7], 192'd1);

      // TIMEOUT=8 instance: finish coincides with the last allowed BUSY cycle
      apply_reset();
      set_req(7, 1'b0, 12'h123, 8'h00);
      step();
      req_valid = '0;
      for (int k = 0; k < 7; k++) step();
      finish[7] = 1'b1;
      data_out[56 +: 8] = 8'hA5;
      step();
      finish = '0;
      chk("r42_rsp_valid", t_rsp_valid[7], 192'd1);
      chk("r42_rsp_err", t_rsp_err[7], 192'd0);
      chk("r42_rsp_data", t_rsp_data[63:56], 192'hA5);
      step();

      // default TIMEOUT: finish on the 64th BUSY cycle, then a full timeout
      apply_reset();
      set_req(5, 1'b0, 12'hB05, 8'h00);
      step();
      req_valid = '0;
      for (int k = 0; k < TMO - 1; k++) step();
      finish[5] = 1'b1;
      data_out[40 +: 8] = 8'h5C;
      step();
      finish = '0;
      chk("bnd_rsp_err", rsp_err[5], 192'd0);
      chk("bnd_rsp_data", rsp_data[47:40], 192'h5C);
      step();
      set_req(5, 1'b0, 12'hB06, 8'h00);
      step();
      req_valid = '0;
      for (int k = 0; k < TMO; k++) step();
      chk("tmo_rsp_valid", rsp_valid[5], 192'd1);
      chk("tmo_rsp_err", rsp_err[5], 192'd1);
      chk("tmo_rsp_data_held", rsp_data[47:40], 192'h5C);
      step();

      // all cores request together, finished in reverse order
      apply_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(1)), 12'($urandom), 8'($urandom));
      step();
      req_valid = '0;
      chk("r43_busy_cnt", busy_cnt, 192'd16);
      chk("r43_ready", req_ready, 192'h0000);
      for (int i = N - 1; i >= 0; i--) begin
         finish = N'(1) << i;
         data_out = {$urandom, $urandom, $urandom, $urandom};
         step();
         chk("r43_order", rsp_valid, 192'(N'(1) << i));
      end
      finish = '0;
      step();

      // reset during core 2 BUSY, finish after release is spurious
      apply_reset();
      set_req(2, 1'b0, 12'h222, 8'h00);
      step();
      req_valid = '0;
      step();
      apply_reset();
      finish[2] = 1'b1;
      step();
      finish = '0;
      chk("r44_no_rsp", rsp_valid[2], 192'd0);
      chk("r44_spurious", spurious_cnt, 192'd1);

      // multiple spurious bits count once; counter saturates
      apply_reset();
      finish = '1;
      step();
      chk("spur_multi", spurious_cnt, 192'd1);
      finish = N'(1);
      for (int k = 0; k < 260; k++) step();
      finish = '0;
      chk("spur_sat", spurious_cnt, 192'd255);

      // random traffic
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(2) == 0);
            req_we[i] = 1'($urandom_range(1));
            req_addr[12*i +: 12] = 12'($urandom);
            req_wdata[8*i +: 8] = 8'($urandom);
            finish[i] = pend[i] ? ($urandom_range(15) == 0) : ($urandom_range(60) == 0);
         end
         data_out = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
